// File: rtl/issue_scoreboard_if.sv
// Decode/writeback/issue bundle between decode, the execution pipes and the issue scoreboard.
// master = decode/pipe side driving the scoreboard; slave = the scoreboard itself.
interface issue_scoreboard_if #(
  parameter int REG_WIDTH = 5
);
  logic                   flush;
  logic                   id_valid;
  logic [3:0]             id_exe_pipe;
  logic [REG_WIDTH-1:0]   id_a1;
  logic [REG_WIDTH-1:0]   id_a2;
  logic [REG_WIDTH-1:0]   id_rd;
  logic                   id_register_write;
  logic [3:0]             wb_valid;
  logic [4*REG_WIDTH-1:0] wb_rd;
  logic                   lsu_done;
  logic                   issue_valid;
  logic [3:0]             issue_pipe;
  logic                   stall;
  logic                   div_busy;

  modport master (
    output flush, id_valid, id_exe_pipe, id_a1, id_a2, id_rd, id_register_write,
    output wb_valid, wb_rd, lsu_done,
    input  issue_valid, issue_pipe, stall, div_busy
  );

  modport slave (
    input  flush, id_valid, id_exe_pipe, id_a1, id_a2, id_rd, id_register_write,
    input  wb_valid, wb_rd, lsu_done,
    output issue_valid, issue_pipe, stall, div_busy
  );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: RAW/WAW/structural stall, one-hot issue, DIV busy and LSU credit tracking.
// Optional macro ISSUE_SCOREBOARD_WB_BYPASS_EN lets same-cycle writebacks release hazards.
module issue_scoreboard #(
  parameter int NUM_REGS            = 32,
  parameter int REG_WIDTH           = 5,
  parameter int LSU_MAX_OUTSTANDING = 2
) (
  input logic           clk,
  input logic           rst,
  issue_scoreboard_if.slave bus
);
  localparam int CNT_W = 3;
  localparam logic [CNT_W:0] LSU_LIMIT = (CNT_W+1)'(LSU_MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] release_s;
  logic [NUM_REGS-1:0] pending_eff_s;
  logic                div_busy_q;
  logic                div_busy_d;
  logic                div_eff_s;
  logic [CNT_W-1:0]    lsu_count_q;
  logic [CNT_W-1:0]    lsu_count_d;
  logic [CNT_W:0]      lsu_net_s;
  logic                raw_s;
  logic                waw_s;
  logic                struct_s;
  logic                decode_s;
  logic                go_s;
  logic                set_s;
  logic                lsu_inc_s;

  // Registers released by any pipe writing back this cycle.
  always_comb begin
    release_s = '0;
    for (int i = 0; i < 4; i++) begin
      release_s[bus.wb_rd[i*REG_WIDTH +: REG_WIDTH]] =
        release_s[bus.wb_rd[i*REG_WIDTH +: REG_WIDTH]] | bus.wb_valid[i];
    end
    release_s[0] = 1'b0;
  end

`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
  assign pending_eff_s = pending_q & ~release_s;
  assign div_eff_s     = div_busy_q & ~bus.wb_valid[2];
`else
  assign pending_eff_s = pending_q;
  assign div_eff_s     = div_busy_q;
`endif

  // Hazard evaluation and issue/stall outputs.
  always_comb begin
    raw_s     = ((bus.id_a1 != '0) & pending_eff_s[bus.id_a1]) |
                ((bus.id_a2 != '0) & pending_eff_s[bus.id_a2]);
    waw_s     = bus.id_register_write & (bus.id_rd != '0) & pending_eff_s[bus.id_rd];
    // LSU credit returned this cycle is usable by the op in decode.
    lsu_net_s = {1'b0, lsu_count_q} - {{CNT_W{1'b0}}, bus.lsu_done};
    struct_s  = (bus.id_exe_pipe[2] & div_eff_s) |
                (bus.id_exe_pipe[3] & (lsu_net_s == LSU_LIMIT));
    decode_s  = bus.id_valid & ~bus.flush & (bus.id_exe_pipe != 4'b0000);
    go_s      = decode_s & ~(raw_s | waw_s | struct_s);
    bus.issue_valid = go_s;
    bus.stall       = decode_s & (raw_s | waw_s | struct_s);
    if (go_s) begin
      bus.issue_pipe = bus.id_exe_pipe;
    end else begin
      bus.issue_pipe = 4'b0000;
    end
  end

  assign bus.div_busy = div_busy_q;

  // Next-state: clears first, then a new destination set wins.
  always_comb begin
    set_s     = go_s & bus.id_register_write & (bus.id_rd != '0);
    pending_d = pending_q & ~release_s;
    pending_d[bus.id_rd] = pending_d[bus.id_rd] | set_s;
    pending_d[0] = 1'b0;

    if (go_s & bus.id_exe_pipe[2]) begin
      div_busy_d = 1'b1;
    end else if (bus.wb_valid[2]) begin
      div_busy_d = 1'b0;
    end else begin
      div_busy_d = div_busy_q;
    end

    lsu_inc_s = go_s & bus.id_exe_pipe[3];
    case ({lsu_inc_s, bus.lsu_done})
      2'b10:   lsu_count_d = lsu_count_q + 3'd1;
      2'b01:   lsu_count_d = (lsu_count_q == 3'd0) ? 3'd0 : lsu_count_q - 3'd1;
      default: lsu_count_d = lsu_count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      div_busy_q  <= 1'b0;
      lsu_count_q <= 3'd0;
    end else begin
      pending_q   <= pending_d;
      div_busy_q  <= div_busy_d;
      lsu_count_q <= lsu_count_d;
    end
  end

  issue_scoreboard_chk u_chk (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (bus.id_valid),
    .id_exe_pipe (bus.id_exe_pipe)
  );
endmodule

// Protocol checks on the decode side: at most one pipe selected per instruction.
module issue_scoreboard_chk (
  input logic       clk,
  input logic       rst,
  input logic       id_valid,
  input logic [3:0] id_exe_pipe
);
  a_pipe_onehot: assert property (@(posedge clk) disable iff (rst)
    id_valid |-> $onehot0(id_exe_pipe));
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed-vector bench for issue_scoreboard; expectations follow ISSUE_SCOREBOARD_WB_BYPASS_EN.
module tb_issue_scoreboard;
  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] ALU  = 4'b0001;
  localparam logic [3:0] MUL  = 4'b0010;
  localparam logic [3:0] DIV  = 4'b0100;
  localparam logic [3:0] LSU  = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  issue_scoreboard_if #(.REG_WIDTH(5)) bus ();

  issue_scoreboard #(
    .NUM_REGS            (32),
    .REG_WIDTH           (5),
    .LSU_MAX_OUTSTANDING (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input int iv, input logic [3:0] ip, input int st);
    check({tag, "_iv"}, 32'(bus.issue_valid), 32'(iv));
    check({tag, "_ip"}, 32'(bus.issue_pipe),  32'(ip));
    check({tag, "_st"}, 32'(bus.stall),       32'(st));
  endtask

  function automatic logic [19:0] wbr(input int p, input int r);
    logic [19:0] t;
    t = {15'd0, 5'(r)};
    return t << (5 * p);
  endfunction

  // Apply one cycle of inputs at the falling edge; outputs settle 1 ns later.
  task automatic cyc(input int v, input logic [3:0] pipe, input int a1, input int a2,
                     input int rd, input int rw, input int fl, input logic [3:0] wbv,
                     input logic [19:0] wbrd, input int ld);
    @(negedge clk);
    bus.id_valid          = 1'(v);
    bus.id_exe_pipe       = pipe;
    bus.id_a1             = 5'(a1);
    bus.id_a2             = 5'(a2);
    bus.id_rd             = 5'(rd);
    bus.id_register_write = 1'(rw);
    bus.flush             = 1'(fl);
    bus.wb_valid          = wbv;
    bus.wb_rd             = wbrd;
    bus.lsu_done          = 1'(ld);
    #1;
  endtask

  task automatic idle();
    cyc(0, NONE, 0, 0, 0, 0, 0, 4'b0000, 20'd0, 0);
  endtask

  initial begin
    bus.id_valid = 1'b0; bus.id_exe_pipe = NONE; bus.id_a1 = 5'd0; bus.id_a2 = 5'd0;
    bus.id_rd = 5'd0; bus.id_register_write = 1'b0; bus.flush = 1'b0;
    bus.wb_valid = 4'b0000; bus.wb_rd = 20'd0; bus.lsu_done = 1'b0;
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    exp_out("rst", 0, NONE, 0);
    check("rst_busy", 32'(bus.div_busy), 32'd0);

    // Independent ALU ops, then RAW/WAW on their destinations.
    cyc(1, ALU, 1, 2, 5, 1, 0, 4'b0000, 20'd0, 0);  exp_out("t1_iss0", 1, ALU, 0);
    cyc(1, ALU, 1, 2, 11, 1, 0, 4'b0000, 20'd0, 0); exp_out("t1_iss1", 1, ALU, 0);
    cyc(1, ALU, 1, 2, 12, 1, 0, 4'b0000, 20'd0, 0); exp_out("t1_iss2", 1, ALU, 0);
    cyc(1, ALU, 5, 2, 13, 1, 0, 4'b0000, 20'd0, 0); exp_out("t1_raw", 0, NONE, 1);
    cyc(1, ALU, 5, 2, 13, 1, 0, 4'b0001, wbr(0, 5), 0);
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    exp_out("t1_rel", 1, ALU, 0);
`else
    exp_out("t1_rel", 0, NONE, 1);
    cyc(1, ALU, 5, 2, 13, 1, 0, 4'b0000, 20'd0, 0); exp_out("t1_rel_late", 1, ALU, 0);
`endif
    cyc(1, ALU, 0, 0, 11, 1, 0, 4'b0000, 20'd0, 0); exp_out("t1_waw", 0, NONE, 1);
    cyc(0, ALU, 11, 12, 13, 1, 0, 4'b0111, wbr(0, 11) | wbr(1, 12) | wbr(2, 13), 0);
    exp_out("t1_noval", 0, NONE, 0);
    cyc(1, ALU, 11, 12, 13, 1, 0, 4'b0000, 20'd0, 0); exp_out("t1_clr", 1, ALU, 0);
    cyc(0, NONE, 0, 0, 0, 0, 0, 4'b0001, wbr(0, 13), 0);

    // RAW on a MUL result released at the fourth cycle.
    cyc(1, MUL, 1, 2, 7, 1, 0, 4'b0000, 20'd0, 0); exp_out("t2_mul", 1, MUL, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, ALU, 7, 0, 14, 1, 0, 4'b0000, 20'd0, 0); exp_out("t2_raw", 0, NONE, 1);
    end
    cyc(1, ALU, 7, 0, 14, 1, 0, 4'b0010, wbr(1, 7), 0);
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    exp_out("t2_rel", 1, ALU, 0);
`else
    exp_out("t2_rel", 0, NONE, 1);
    cyc(1, ALU, 7, 0, 14, 1, 0, 4'b0000, 20'd0, 0); exp_out("t2_rel_late", 1, ALU, 0);
`endif
    cyc(0, NONE, 0, 0, 0, 0, 0, 4'b0001, wbr(0, 14), 0);

    // Single-entry DIV structural hazard.
    cyc(1, DIV, 1, 0, 3, 1, 0, 4'b0000, 20'd0, 0); exp_out("t3_div0", 1, DIV, 0);
    check("t3_busy0", 32'(bus.div_busy), 32'd0);
    cyc(1, DIV, 1, 0, 4, 1, 0, 4'b0000, 20'd0, 0); exp_out("t3_struct", 0, NONE, 1);
    check("t3_busy1", 32'(bus.div_busy), 32'd1);
    cyc(1, DIV, 1, 0, 4, 1, 0, 4'b0100, wbr(2, 3), 0);
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    exp_out("t3_rel", 1, DIV, 0);
`else
    exp_out("t3_rel", 0, NONE, 1);
    cyc(1, DIV, 1, 0, 4, 1, 0, 4'b0000, 20'd0, 0); exp_out("t3_rel_late", 1, DIV, 0);
    check("t3_busy_gap", 32'(bus.div_busy), 32'd0);
`endif
    idle(); check("t3_busy_kept", 32'(bus.div_busy), 32'd1);
    cyc(0, NONE, 0, 0, 0, 0, 0, 4'b0100, wbr(2, 4), 0);
    check("t3_busy_wb", 32'(bus.div_busy), 32'd1);
    idle(); check("t3_busy_free", 32'(bus.div_busy), 32'd0);

    // LSU outstanding limit of two.
    cyc(1, LSU, 1, 0, 8, 1, 0, 4'b0000, 20'd0, 0);  exp_out("t4_ld0", 1, LSU, 0);
    cyc(1, LSU, 1, 0, 9, 1, 0, 4'b0000, 20'd0, 0);  exp_out("t4_ld1", 1, LSU, 0);
    cyc(1, LSU, 1, 0, 10, 1, 0, 4'b0000, 20'd0, 0); exp_out("t4_full", 0, NONE, 1);
    cyc(1, LSU, 1, 0, 10, 1, 0, 4'b0000, 20'd0, 1); exp_out("t4_done", 1, LSU, 0);
    cyc(1, LSU, 1, 0, 15, 1, 0, 4'b0000, 20'd0, 0); exp_out("t4_still", 0, NONE, 1);
    cyc(0, NONE, 0, 0, 0, 0, 0, 4'b1000, wbr(3, 8), 1);
    cyc(0, NONE, 0, 0, 0, 0, 0, 4'b1000, wbr(3, 9), 1);
    cyc(0, NONE, 0, 0, 0, 0, 0, 4'b1000, wbr(3, 10), 0);
    cyc(1, LSU, 0, 0, 0, 0, 0, 4'b0000, 20'd0, 0); exp_out("t4_empty", 1, LSU, 0);
    cyc(0, NONE, 0, 0, 0, 0, 0, 4'b0000, 20'd0, 1);

    // x0 destination, flush and invalid pipe.
    cyc(1, DIV, 0, 0, 0, 1, 0, 4'b0000, 20'd0, 0); exp_out("t5_div_x0", 1, DIV, 0);
    cyc(1, ALU, 0, 0, 0, 1, 0, 4'b0000, 20'd0, 0); exp_out("t5_alu_x0", 1, ALU, 0);
    check("t5_busy", 32'(bus.div_busy), 32'd1);
    cyc(1, MUL, 1, 2, 6, 1, 1, 4'b0100, wbr(2, 0), 0); exp_out("t5_flush", 0, NONE, 0);
    cyc(1, ALU, 6, 0, 0, 0, 0, 4'b0000, 20'd0, 0); exp_out("t5_x6_free", 1, ALU, 0);
    cyc(1, NONE, 1, 2, 6, 1, 0, 4'b0000, 20'd0, 0); exp_out("t5_bubble", 0, NONE, 0);
    cyc(1, DIV, 0, 0, 0, 0, 0, 4'b0000, 20'd0, 0); exp_out("t5_div2", 1, DIV, 0);
    cyc(1, DIV, 0, 0, 0, 0, 1, 4'b0000, 20'd0, 0); exp_out("t5_flush_haz", 0, NONE, 0);
    cyc(0, NONE, 0, 0, 0, 0, 0, 4'b0100, wbr(2, 0), 0);

    // Reset mid-flight; late writeback after reset is ignored.
    cyc(1, MUL, 1, 2, 7, 1, 0, 4'b0000, 20'd0, 0); exp_out("t6_mul", 1, MUL, 0);
    cyc(1, DIV, 0, 0, 3, 1, 0, 4'b0000, 20'd0, 0); exp_out("t6_div", 1, DIV, 0);
    cyc(1, ALU, 7, 3, 0, 0, 0, 4'b0000, 20'd0, 0); exp_out("t6_pre", 0, NONE, 1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    idle(); check("t6_busy_rst", 32'(bus.div_busy), 32'd0);
    cyc(0, NONE, 0, 0, 0, 0, 0, 4'b0010, wbr(1, 7), 0);
    cyc(1, ALU, 7, 3, 0, 0, 0, 4'b0000, 20'd0, 0); exp_out("t6_alu", 1, ALU, 0);
    cyc(1, DIV, 0, 0, 0, 0, 0, 4'b0000, 20'd0, 0); exp_out("t6_div2", 1, DIV, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
